// File: rtl/axis_packetizer_pkg.sv
// Shared types and widths for the ping-pong AXI4-Stream packetizer.
package axis_packetizer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } out_state_e;

    // Header beat carries a 16-bit packet sequence number
    localparam int unsigned SEQ_W     = 16;
    localparam int unsigned HDR_BEATS = 1;

    function automatic int unsigned idx_width(input int unsigned len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

    localparam int unsigned PKT_LEN_DEF = 8;
    localparam int unsigned IDX_W_DEF   = idx_width(PKT_LEN_DEF);

endpackage

// File: rtl/pp_bank_buffer.sv
// Two-bank word store with per-bank full flags; read port is a plain mux.
module pp_bank_buffer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned IDX_W   = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              set_full,
    input  logic              clr_full,
    input  logic              rd_bank,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        full
);

    logic [DATA_W-1:0] mem [2][PKT_LEN];

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_bank][wr_idx] <= wr_data;
    end

    // Set and clear never address the same bank: writer only fills an empty bank
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full <= 2'b00;
        end else begin
            if (set_full) full[wr_bank] <= 1'b1;
            if (clr_full) full[rd_bank] <= 1'b0;
        end
    end

    assign rd_data = mem[rd_bank][rd_idx];

endmodule

// File: rtl/axis_packetizer_pp.sv
// Ping-pong packetizer: gathers PKT_LEN strobed words per bank, streams each full bank.
// Optional header beat with sequence number when AXIS_PKT_HEADER_EN is defined.
module axis_packetizer_pp
    import axis_packetizer_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    input  logic              flush,
    output logic [DATA_W-1:0] TDATA,
    output logic              TVALID,
    output logic              TLAST,
    input  logic              TREADY,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_cnt
);

    localparam int unsigned     IDX_W    = idx_width(PKT_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

    logic              wbank, rbank;
    logic [IDX_W-1:0]  widx, ridx, ridx_d, rd_idx;
    logic [1:0]        full;
    logic [DATA_W-1:0] rd_data, tdata_d;
    logic              tvalid_d, tlast_d, release_c;
    logic              wr_take, wr_drop, wr_done;
    out_state_e        state, state_d;
`ifdef AXIS_PKT_HEADER_EN
    logic [SEQ_W-1:0]  seq;
`endif

    // A bank clearing this cycle still reads as full, so that write is dropped
    assign wr_take = valid & ~flush & ~full[wbank];
    assign wr_drop = valid & ~flush &  full[wbank];
    assign wr_done = wr_take & (widx == LAST_IDX);

    pp_bank_buffer #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN),
        .IDX_W   (IDX_W)
    ) u_buf (
        .clock    (clock),
        .reset_n  (reset_n),
        .wr_en    (wr_take),
        .wr_bank  (wbank),
        .wr_idx   (widx),
        .wr_data  (data_in),
        .set_full (wr_done),
        .clr_full (release_c),
        .rd_bank  (rbank),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .full     (full)
    );

    // Write side: index, bank toggle, drop accounting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            widx     <= '0;
            wbank    <= 1'b0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (flush) begin
                widx <= '0;
            end else if (wr_take) begin
                if (wr_done) begin
                    widx  <= '0;
                    wbank <= ~wbank;
                end else begin
                    widx <= widx + IDX_W'(1);
                end
            end
            if (wr_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

    // Output FSM state and registered stream outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            ridx   <= '0;
            rbank  <= 1'b0;
            TVALID <= 1'b0;
            TLAST  <= 1'b0;
            TDATA  <= '0;
        end else begin
            state  <= state_d;
            ridx   <= ridx_d;
            rbank  <= rbank ^ release_c;
            TVALID <= tvalid_d;
            TLAST  <= tlast_d;
            TDATA  <= tdata_d;
        end
    end

`ifdef AXIS_PKT_HEADER_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       seq <= '0;
        else if (release_c) seq <= seq + SEQ_W'(1);
    end
`endif

    // Next beat is fetched one cycle ahead so outputs stay registered
    always_comb begin
        state_d   = state;
        ridx_d    = ridx;
        tvalid_d  = TVALID;
        tlast_d   = TLAST;
        tdata_d   = TDATA;
        release_c = 1'b0;
        rd_idx    = '0;
        case (state)
            ST_IDLE: begin
                if (full[rbank]) begin
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    ridx_d   = '0;
`ifdef AXIS_PKT_HEADER_EN
                    state_d  = ST_HDR;
                    tdata_d  = DATA_W'(seq);
`else
                    state_d  = ST_DATA;
                    tdata_d  = rd_data;
`endif
                end
            end
`ifdef AXIS_PKT_HEADER_EN
            ST_HDR: begin
                if (TREADY) begin
                    state_d = ST_DATA;
                    tdata_d = rd_data;
                    tlast_d = 1'b0;
                end
            end
`endif
            ST_DATA: begin
                rd_idx = (ridx == LAST_IDX) ? '0 : ridx + IDX_W'(1);
                if (TREADY) begin
                    if (ridx == LAST_IDX) begin
                        release_c = 1'b1;
                        state_d   = ST_IDLE;
                        tvalid_d  = 1'b0;
                        tlast_d   = 1'b0;
                        tdata_d   = '0;
                    end else begin
                        ridx_d  = rd_idx;
                        tdata_d = rd_data;
                        tlast_d = (rd_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axis_packetizer_pp.sv
// Bench for axis_packetizer_pp: queue-based stream model, per-cycle compare, directed + random traffic.
module tb_axis_packetizer_pp;

    localparam int PKT_LEN = 8;
`ifdef AXIS_PKT_HEADER_EN
    localparam int HOFF = 1;
`else
    localparam int HOFF = 0;
`endif
    localparam int BEATS = PKT_LEN + HOFF;

    logic        clock, reset_n;
    logic [31:0] data_in;
    logic        valid, flush;
    logic [31:0] TDATA;
    logic        TVALID, TLAST, TREADY;
    logic        overflow;
    logic [15:0] drop_cnt;

    axis_packetizer_pp #(.DATA_W(32), .PKT_LEN(PKT_LEN), .CNT_W(16)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data_in  (data_in),
        .valid    (valid),
        .flush    (flush),
        .TDATA    (TDATA),
        .TVALID   (TVALID),
        .TLAST    (TLAST),
        .TREADY   (TREADY),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_pass = 0;
    bit checking = 0;

    // Model: completed packets (flattened words), cycle each becomes available, partial fill
    logic [31:0] pend_data[$];
    int          avail_q[$];
    logic [31:0] partial[$];
    int          bidx, last_rel, seq, cyc, m_dc;
    bit          m_ovf;

    bit          p_hold;
    logic [31:0] p_data;
    logic        p_last;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        pend_data.delete();
        avail_q.delete();
        partial.delete();
        bidx = 0; last_rel = -10; seq = 0; cyc = 0; m_dc = 0; m_ovf = 0; p_hold = 0;
    endtask

    function automatic bit m_tvalid();
        int s;
        if (avail_q.size() == 0) return 1'b0;
        s = avail_q[0];
        if (last_rel + 1 > s) s = last_rel + 1;
        return cyc >= s;
    endfunction

    function automatic logic [31:0] exp_beat();
        if (HOFF == 1 && bidx == 0) return 32'(seq % 65536);
        return pend_data[bidx - HOFF];
    endfunction

    // Advance the model across one rising edge given the inputs seen at that edge
    task automatic model_edge(input bit v, input bit f, input logic [31:0] d, input bit r);
        bit etv;
        int occ;
        logic [31:0] junk;
        etv = m_tvalid();
        occ = avail_q.size();
        if (f) begin
            partial.delete();
        end else if (v) begin
            if (occ == 2) begin
                m_ovf = 1;
                if (m_dc < 65535) m_dc++;
            end else begin
                partial.push_back(d);
                if (partial.size() == PKT_LEN) begin
                    foreach (partial[i]) pend_data.push_back(partial[i]);
                    avail_q.push_back(cyc + 2);
                    partial.delete();
                end
            end
        end
        if (etv && r) begin
            bidx++;
            if (bidx == BEATS) begin
                for (int i = 0; i < PKT_LEN; i++) junk = pend_data.pop_front();
                void'(avail_q.pop_front());
                last_rel = cyc + 1;
                bidx = 0;
                seq++;
            end
        end
        cyc++;
    endtask

    task automatic step(input bit v, input bit f, input logic [31:0] d, input bit r);
        valid = v; flush = f; data_in = d; TREADY = r;
        @(posedge clock);
        #1;
        model_edge(v, f, d, r);
    endtask

    // Compare process: every cycle against the model, plus AXI hold stability
    always @(negedge clock) begin
        if (checking) begin
            bit etv;
            etv = m_tvalid();
            chk("tvalid", 64'(TVALID), 64'(etv));
            if (etv) begin
                chk("tdata", 64'(TDATA), 64'(exp_beat()));
                chk("tlast", 64'(TLAST), 64'(bidx == BEATS - 1));
            end else begin
                chk("tlast_idle", 64'(TLAST), 64'(0));
            end
            chk("overflow", 64'(overflow), 64'(m_ovf));
            chk("drop_cnt", 64'(drop_cnt), 64'(m_dc));
            if (p_hold) begin
                chk("hold_tvalid", 64'(TVALID), 64'(1));
                chk("hold_tdata", 64'(TDATA), 64'(p_data));
                chk("hold_tlast", 64'(TLAST), 64'(p_last));
            end
            p_hold = TVALID && !TREADY;
            p_data = TDATA;
            p_last = TLAST;
        end
    end

    // Send one packet with TREADY=1 and pin its beats with literal expectations
    task automatic lit_packet(input logic [31:0] base);
        logic [31:0] e;
        for (int i = 0; i < PKT_LEN; i++) step(1, 0, base + 32'(i), 1);
        chk("lit_gap", 64'(TVALID), 64'(0));
        for (int i = 0; i < BEATS; i++) begin
            step(0, 0, 0, 1);
            e = (HOFF == 1) ? ((i == 0) ? 32'(seq % 65536) : base + 32'(i - 1)) : base + 32'(i);
            chk("lit_tvalid", 64'(TVALID), 64'(1));
            chk("lit_tdata", 64'(TDATA), 64'(e));
            chk("lit_tlast", 64'(TLAST), 64'(i == BEATS - 1));
        end
        step(0, 0, 0, 1);
        chk("lit_bubble", 64'(TVALID), 64'(0));
    endtask

    initial begin
        int rmode;
        bit v, f, r;
        clock = 0; reset_n = 1; valid = 0; flush = 0; data_in = 0; TREADY = 0;
        model_reset();
        #2 reset_n = 0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_tvalid", 64'(TVALID), 64'(0));
        chk("rst_tlast", 64'(TLAST), 64'(0));
        chk("rst_tdata", 64'(TDATA), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_drop_cnt", 64'(drop_cnt), 64'(0));
        reset_n = 1;
        checking = 1;

        // Single packet, full throughput
        lit_packet(32'h100);
        chk("t1_overflow", 64'(overflow), 64'(0));

        // Partial fill discarded by flush
        for (int i = 0; i < 3; i++) step(1, 0, 32'h90 + 32'(i), 1);
        step(0, 1, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, 32'hA0 + 32'(i), 1);
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1);
        chk("t4_drop_cnt", 64'(drop_cnt), 64'(0));

        // TREADY toggling mid-packet
        for (int i = 0; i < 8; i++) step(1, 0, 32'h200 + 32'(i), 0);
        for (int i = 0; i < 24; i++) step(0, 0, 0, bit'(i % 2));
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

        // Stalled sink: both banks fill, then words drop
        for (int i = 0; i < 20; i++) step(1, 0, 32'(i), 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("t2_overflow", 64'(overflow), 64'(1));
        chk("t2_drop_cnt", 64'(drop_cnt), 64'(4));
        for (int i = 0; i < 30; i++) step(0, 0, 0, 1);

        // Reset on the fourth beat of a packet
        for (int i = 0; i < 8; i++) step(1, 0, 32'h50 + 32'(i), 1);
        for (int k = 0; k < 30 && !(m_tvalid() && bidx == 3); k++) step(0, 0, 0, 1);
        chk("beat4_tvalid", 64'(TVALID), 64'(1));
        chk("beat4_tdata", 64'(TDATA), 64'(32'h50 + 32'(3 - HOFF)));
        checking = 0;
        reset_n = 0;
        #1;
        chk("midrst_tvalid", 64'(TVALID), 64'(0));
        chk("midrst_tlast", 64'(TLAST), 64'(0));
        chk("midrst_drop_cnt", 64'(drop_cnt), 64'(0));
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1;
        checking = 1;
        lit_packet(32'h60);

        // Random traffic with bursty back-pressure
        rmode = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 50 == 0) rmode = $urandom_range(0, 2);
            v = ($urandom_range(0, 9) < 6);
            f = ($urandom_range(0, 49) == 0);
            case (rmode)
                0: r = 1;
                1: r = $urandom_range(0, 1) == 1;
                default: r = ($urandom_range(0, 9) == 0);
            endcase
            step(v, f, $urandom, r);
        end
        for (int i = 0; i < 40; i++) step(0, 0, 0, 1);
        chk("final_tvalid", 64'(TVALID), 64'(0));

        checking = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
